// File: rtl/hdmi_cfg_pkg.sv
// hdmi_cfg_pkg: shared types, VIC lookup and default register table for the HDMI config sequencer
package hdmi_cfg_pkg;
  typedef enum logic [2:0] {S_SETTLE, S_LOAD, S_REQ, S_WAIT, S_NEXT, S_DONE, S_ERROR} state_t;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;
  localparam int TABLE_LEN = 32;
  localparam entry_t CFG_TABLE [TABLE_LEN] = '{
    16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'h3C00, 16'hA2A4, 16'hA3A4,
    16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1700, 16'h1846, 16'hAF06, 16'h4080,
    16'h4C04, 16'hBA60, 16'hD6C0, 16'h5512, 16'h5628, 16'h9620, 16'hD03C, 16'hE460,
    16'hFA7D, 16'hDE9C, 16'hE2E0, 16'hA544, 16'hAB40, 16'h9480, 16'h0A01, 16'h0100
  };
  function automatic logic [7:0] vic_lut(input logic [3:0] mode);
    case (mode)
      4'd0: return 8'h01;
      4'd1: return 8'h04;
      4'd2: return 8'h10;
      4'd3: return 8'h02;
      4'd4: return 8'h13;
      4'd5: return 8'h1F;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/hdmi_cfg_rom.sv
// hdmi_cfg_rom: combinational register-table lookup, entries past the table read as zero
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
#(
  parameter int N_REGS = 32
) (
  input  logic [7:0] idx,
  output entry_t     entry
);
  assign entry = (idx < 8'(N_REGS) && idx < 8'(TABLE_LEN)) ? CFG_TABLE[idx[4:0]] : '0;
endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// hdmi_cfg_sequencer: walks the register table through an I2C byte-write engine, restarting on hot-plug or mode change
module hdmi_cfg_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter int         N_REGS     = 32,
  parameter logic [7:0] DEV_ADDR   = 8'h72,
  parameter int         SETTLE_CYC = 1_000_000,
  parameter int         RETRY_MAX  = 3,
  parameter int         VIC_IDX    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_int,
  input  logic [3:0] mode,
  input  logic       mode_change,
  output logic       wr_req,
  output logic [7:0] wr_dev,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  input  logic       wr_nack,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [7:0] err_count
);
  state_t      state, state_next;
  logic [31:0] settle_cnt;
  logic [7:0]  idx, retry;
  logic        sync1, sync2, sync_q, restart_pend;
  logic        hot_plug, ack, restart_clr;
  entry_t      rom_entry;

  hdmi_cfg_rom #(.N_REGS(N_REGS)) u_rom (.idx(idx), .entry(rom_entry));

  assign hot_plug    = sync_q & ~sync2;
  assign ack         = wr_req & wr_ack;
  assign restart_clr = restart_pend & (state_next == S_SETTLE);
  assign wr_req      = state inside {S_REQ, S_WAIT};
  assign busy        = !(state inside {S_DONE, S_ERROR});
  assign cfg_done    = state == S_DONE;
  assign cfg_error   = state == S_ERROR;

  // state register
  always_ff @(posedge clk)
    state <= reset ? S_SETTLE : state_next;

  // next state: a pending restart wins everywhere except mid-handshake, where it waits for wr_ack
  always_comb begin
    state_next = state;
    case (state)
      S_SETTLE:      state_next = (!restart_pend && settle_cnt == 32'(SETTLE_CYC - 1)) ? S_LOAD : S_SETTLE;
      S_LOAD:        state_next = restart_pend ? S_SETTLE : S_REQ;
      S_REQ, S_WAIT: state_next = !ack ? S_WAIT : restart_pend ? S_SETTLE : !wr_nack ? S_NEXT :
                                  retry < 8'(RETRY_MAX) ? S_LOAD : S_ERROR;
      S_NEXT:        state_next = restart_pend ? S_SETTLE : idx == 8'(N_REGS - 1) ? S_DONE : S_LOAD;
      S_DONE,
      S_ERROR:       state_next = restart_pend ? S_SETTLE : state;
      default:       state_next = S_SETTLE;
    endcase
  end

  // datapath: synchronizer, restart flag, counters and the latched write fields
  always_ff @(posedge clk) begin
    if (reset) begin
      {sync1, sync2, sync_q} <= 3'b111;
      restart_pend <= 1'b0;
      settle_cnt   <= '0;
      idx          <= '0;
      retry        <= '0;
      err_count    <= '0;
      wr_dev       <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      {sync1, sync2, sync_q} <= {tx_int, sync1, sync2};
      restart_pend <= (restart_pend & ~restart_clr) | hot_plug | mode_change;
      settle_cnt   <= (state == S_SETTLE && !restart_pend) ? settle_cnt + 32'd1 : '0;
      idx          <= state == S_SETTLE ? '0 : (state == S_NEXT && state_next == S_LOAD) ? idx + 8'd1 : idx;
      retry        <= (state == S_SETTLE || (ack && !wr_nack)) ? '0 :
                      (ack && state_next == S_LOAD) ? retry + 8'd1 : retry;
      err_count    <= (ack && wr_nack && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
      if (state == S_LOAD) begin
        wr_dev  <= DEV_ADDR;
        wr_addr <= rom_entry.addr;
        wr_data <= idx == 8'(VIC_IDX) ? vic_lut(mode) : rom_entry.data;
      end
    end
  end
endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// tb_hdmi_cfg_sequencer: randomized scenarios against a transaction-list reference model
module tb_hdmi_cfg_sequencer;
  localparam int RMAX = 2;
  logic       clk, reset, tx_int, mode_change, wr_req, wr_ack, wr_nack, busy, cfg_done, cfg_error;
  logic [3:0] mode;
  logic [7:0] wr_dev, wr_addr, wr_data, err_count;

  hdmi_cfg_sequencer #(.N_REGS(4), .DEV_ADDR(8'h72), .SETTLE_CYC(16), .RETRY_MAX(RMAX), .VIC_IDX(2)) dut (
    .clk(clk), .reset(reset), .tx_int(tx_int), .mode(mode), .mode_change(mode_change),
    .wr_req(wr_req), .wr_dev(wr_dev), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_nack(wr_nack), .busy(busy), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] tbl [4] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30};
  int          n_checks = 0, n_fail = 0;
  int          plan_init [4], plan_left [4];
  int          ack_delay = 3, exp_err = 0;
  bit          exp_fail;
  logic [23:0] log_q [$], exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_vic(input logic [3:0] m);
    case (m)
      4'd0: return 8'h01;
      4'd1: return 8'h04;
      4'd2: return 8'h10;
      4'd3: return 8'h02;
      4'd4: return 8'h13;
      4'd5: return 8'h1F;
      default: return 8'h00;
    endcase
  endfunction

  // expected transactions of one pass over the first n_ent entries under the current NACK plan
  task automatic model_pass(input logic [3:0] m, input int n_ent);
    logic [15:0] e;
    exp_fail = 0;
    for (int i = 0; i < n_ent && !exp_fail; i++) begin
      e = tbl[i];
      if (i == 2) e[7:0] = ref_vic(m);
      for (int a = 0; a <= plan_init[i] && a <= RMAX; a++) exp_q.push_back({8'h72, e});
      exp_err += plan_init[i] > RMAX ? RMAX + 1 : plan_init[i];
      if (plan_init[i] > RMAX) exp_fail = 1;
    end
  endtask

  task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
    plan_init = '{p0, p1, p2, p3};
    plan_left = plan_init;
    log_q.delete();
    exp_q.delete();
  endtask

  // I2C engine stand-in: logs each request, checks field stability, answers after ack_delay cycles
  initial begin
    int          wcnt;
    bit          nk;
    logic [23:0] cur;
    wcnt = 0; nk = 0; cur = '0;
    wr_ack = 1'b0; wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0; wr_nack = 1'b0;
      if (reset || !wr_req) wcnt = 0;
      else begin
        if (wcnt == 0) begin
          cur = {wr_dev, wr_addr, wr_data};
          log_q.push_back(cur);
          nk = 0;
          for (int j = 0; j < 4; j++)
            if (wr_addr == tbl[j][15:8] && plan_left[j] > 0) begin
              nk = 1;
              plan_left[j]--;
            end
        end else check("hold_fields", {8'h0, wr_dev, wr_addr, wr_data}, {8'h0, cur});
        wcnt++;
        if (wcnt == ack_delay) begin
          wr_ack = 1'b1;
          wr_nack = nk;
        end
      end
    end
  end

  task automatic pulse_mode(input logic [3:0] m);
    @(negedge clk);
    mode = m; mode_change = 1'b1;
    @(negedge clk);
    mode_change = 1'b0;
  endtask

  task automatic hot_plug();
    @(negedge clk) tx_int = 1'b0;
    repeat (4) @(negedge clk);
    tx_int = 1'b1;
  endtask

  task automatic wait_req_addr(input logic [7:0] a);
    int k = 0;
    while (!(wr_req && wr_addr == a) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("wait_req", {31'b0, wr_req && wr_addr == a}, 1);
  endtask

  task automatic run_pass();
    int k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("busy_start", busy, 1);
    k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("busy_end", busy, 0);
    check("tx_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) check($sformatf("tx%0d", i), log_q[i], exp_q[i]);
    check("cfg_done", cfg_done, !exp_fail);
    check("cfg_error", cfg_error, exp_fail);
    check("err_count", err_count, exp_err > 255 ? 255 : exp_err);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_err = 0;
  endtask

  initial begin
    int k;
    logic [3:0] m;
    reset = 1'b1; tx_int = 1'b1; mode = 4'd1; mode_change = 1'b0;
    set_plan(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_wr_req", wr_req, 0);
    check("rst_busy", busy, 1);
    check("rst_done", cfg_done, 0);
    check("rst_error", cfg_error, 0);
    check("rst_err_count", err_count, 0);
    check("rst_fields", {8'h0, wr_dev, wr_addr, wr_data}, 0);
    // first request lands in cycle 18 after release: 16 settle cycles, then LOAD
    model_pass(4'd1, 4);
    reset = 1'b0;
    k = 0;
    while (!wr_req && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("first_req_cycle", k + 1, 18);
    run_pass();
    // mode change while DONE re-runs the whole table with the new VIC
    set_plan(0, 0, 0, 0);
    model_pass(4'd3, 4);
    pulse_mode(4'd3);
    run_pass();
    // two NACKs on entry 1 then success
    do_reset();
    set_plan(0, 2, 0, 0);
    model_pass(mode, 4);
    run_pass();
    // retries exhausted on entry 1, then a hot-plug brings a clean pass
    do_reset();
    set_plan(0, 3, 0, 0);
    model_pass(mode, 4);
    run_pass();
    set_plan(0, 0, 0, 0);
    model_pass(mode, 4);
    hot_plug();
    run_pass();
    // hot-plug during WAIT of entry 2: handshake finishes, no entry 3, restart from index 0
    ack_delay = 8;
    set_plan(0, 0, 0, 0);
    model_pass(4'd0, 3);
    model_pass(4'd0, 4);
    pulse_mode(4'd0);
    wait_req_addr(8'h9A);
    tx_int = 1'b0;
    run_pass();
    tx_int = 1'b1;
    repeat (4) @(negedge clk);
    // events arriving on the very DONE->SETTLE edge must cause one extra settle restart
    ack_delay = 3;
    set_plan(0, 0, 0, 0);
    model_pass(4'd2, 4);
    @(negedge clk) tx_int = 1'b0;
    @(negedge clk) begin mode = 4'd2; mode_change = 1'b1; end
    @(negedge clk);
    @(negedge clk) mode_change = 1'b0;
    k = 0;
    while (!wr_req && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("retained_restart_lat", k, 18);
    run_pass();
    repeat (40) @(negedge clk);
    check("no_extra_pass", log_q.size(), 4);
    check("still_done", cfg_done, 1);
    tx_int = 1'b1;
    // reset in the middle of a handshake drops wr_req on the next edge
    set_plan(0, 0, 0, 0);
    pulse_mode(4'd4);
    wait_req_addr(8'h41);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_drops_req", wr_req, 0);
    check("reset_clears_err", err_count, 0);
    @(negedge clk) reset = 1'b0;
    exp_err = 0;
    set_plan(0, 0, 0, 0);
    model_pass(4'd4, 4);
    run_pass();
    // randomized passes: random mode, ack latency and NACK plan
    for (int r = 0; r < 8; r++) begin
      int p [4];
      for (int j = 0; j < 4; j++) begin
        k = $urandom_range(0, 9);
        p[j] = k < 5 ? 0 : k < 8 ? 1 : k < 9 ? 2 : 3;
      end
      m = 4'($urandom_range(0, 15));
      ack_delay = $urandom_range(1, 5);
      set_plan(p[0], p[1], p[2], p[3]);
      model_pass(m, 4);
      pulse_mode(m);
      run_pass();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/hdmi_cfg_sequencer.md
HDMI_CFG_SEQUENCER -- requirements
Module: hdmi_cfg_sequencer

Interface
REQ-001 Parameter N_REGS, default 32: number of entries in the transmitter register table.
REQ-002 Parameter DEV_ADDR, default 8'h72: I2C write address of the HDMI transmitter.
REQ-003 Parameter SETTLE_CYC, default 1_000_000: wait cycles before each configuration pass (20 ms at 50 MHz).
REQ-004 Parameter RETRY_MAX, default 3: NACK retries allowed per entry.
REQ-005 Parameter VIC_IDX, default 5: table index whose data byte is replaced by the mode-derived VIC.
REQ-006 clk  in  1  system clock, single clock domain.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 tx_int  in  1  transmitter interrupt, active-low, asynchronous to clk.
REQ-009 mode  in  4  current video pattern mode.
REQ-010 mode_change  in  1  one-cycle pulse: mode updated.
REQ-011 wr_req  out  1  write-transaction request to the I2C byte-write engine.
REQ-012 wr_dev / wr_addr / wr_data  out  8 each  device address, register address, register data.
REQ-013 wr_ack  in  1  transaction finished, one-cycle pulse.
REQ-014 wr_nack  in  1  transaction failed; valid only together with wr_ack.
REQ-015 busy  out  1  a configuration pass is in progress.
REQ-016 cfg_done  out  1  last pass completed without error.
REQ-017 cfg_error  out  1  last pass aborted after exhausting retries.
REQ-018 err_count  out  8  total NACKs since reset, saturating at 255.

Function
REQ-019 States: SETTLE, LOAD, REQ, WAIT, NEXT, DONE, ERROR.
REQ-020 SETTLE: count SETTLE_CYC cycles, clear index and retry count, then enter LOAD.
REQ-021 LOAD: fetch entry[index] into the output registers; at index==VIC_IDX, data = vic_lut(mode sampled in LOAD); wr_dev = DEV_ADDR.
REQ-022 REQ/WAIT: assert wr_req from the cycle after LOAD; hold wr_req and all three write fields stable until wr_ack; drop wr_req in the cycle after wr_ack.
REQ-023 wr_ack with wr_nack=0: go to NEXT and clear the retry count.
REQ-024 wr_ack with wr_nack=1: increment err_count (saturating). If retry count < RETRY_MAX, increment it and re-issue the same entry via LOAD; otherwise go to ERROR.
REQ-025 NEXT: index==N_REGS-1 -> DONE; otherwise increment index and go to LOAD.
REQ-026 busy = 1 in SETTLE, LOAD, REQ, WAIT, NEXT; 0 in DONE and ERROR.
REQ-027 cfg_done = 1 only in DONE. cfg_error = 1 only in ERROR.
REQ-028 tx_int passes through a 2-flop synchronizer; a 1->0 transition of the synchronized signal is a hot-plug event.
REQ-029 A hot-plug event or mode_change sets a sticky restart_pend flag.
REQ-030 restart_pend in DONE or ERROR: go to SETTLE and clear the flag.
REQ-031 restart_pend in REQ or WAIT: never abort the handshake; on wr_ack (either outcome) go to SETTLE and clear the flag.
REQ-032 restart_pend in LOAD or NEXT: go to SETTLE.
REQ-033 restart_pend in SETTLE: restart the settle count from 0.
REQ-034 An event arriving in the same cycle its flag is cleared is retained, not lost.
REQ-035 wr_ack while wr_req=0 is ignored.

Reset
REQ-036 reset=1 forces SETTLE with settle count 0, index 0, retry count 0, restart_pend 0, err_count 0, wr_req 0, write fields 0, cfg_done 0, cfg_error 0, and synchronizer flops 1.
REQ-037 A reset asserted mid-transaction drops wr_req in the next cycle; the engine handles an abandoned request itself.

Structure
REQ-038 Package hdmi_cfg_pkg holds the state enum, the entry type {addr[7:0], data[7:0]}, the vic_lut function (mode -> VIC; unknown modes -> 0), and the default table constant.
REQ-039 Sub-module hdmi_cfg_rom holds the combinational table lookup (index -> entry).
REQ-040 Size target: 150-300 lines of RTL.

Verification
REQ-041 Bench parameters: SETTLE_CYC=16, N_REGS=4, RETRY_MAX=2, VIC_IDX=2.
REQ-042 Reset release, engine always ACKs after 3 cycles -> first wr_req in cycle 18 (SETTLE 16 + LOAD + 1); exactly 4 transactions in table order with wr_dev=8'h72; then cfg_done=1, busy=0.
REQ-043 mode=4'd1, vic_lut(1)=8'h04 -> the third transaction carries wr_data=8'h04; a mode_change in DONE -> full re-pass with the new VIC.
REQ-044 NACK entry 1 twice, then ACK -> entry 1 issued 3 times; err_count=2; cfg_done=1.
REQ-045 NACK entry 1 three times -> ERROR, cfg_error=1, err_count=3; a subsequent tx_int falling edge -> SETTLE, then a clean pass clears cfg_error.
REQ-046 tx_int falling edge during WAIT of entry 2 -> wr_req and fields held until wr_ack; no entry-3 request; SETTLE follows; the next pass starts at index 0.
REQ-047 mode_change and tx_int edge in the same cycle as a DONE->SETTLE transition -> exactly one additional restart; no event is dropped.
